capp_array: RTL and testbench
=============================

# capp_array

Parametrised associative-processing core: a `CELLS` x `WORD_W` word array with per-cell tag bits. It combines the compare, cell-storage and tag-register functions of the content-addressable parallel processor into one clocked block. A single command port with a valid/ready handshake drives it. It adds multi-write, wired-OR read and responder counting, and is intended to sit under a host sequencer issuing associative programs.

## Interface
- `WORD_W`, 32, bits per cell word and comparand/mask width
- `CELLS`, 100, number of cells (and tag bits)
- `CHUNK`, 16, tags summed per cycle by COUNT
- `CNT_W`, `$clog2(CELLS+1)`, responder-count width (derived, not overridden)
- `CLK` input 1, single clock, rising edge
- `RST_N` input 1, asynchronous active-low reset
- `cmd_valid` input 1, command offered
- `cmd_ready` output 1, block can accept a command
- `cmd_op` input 3, opcode (see Operation)
- `cmd_comparand` input `WORD_W`, search key / write data
- `cmd_mask` input `WORD_W`, 1 = bit participates
- `rsp_valid` output 1, one-cycle completion pulse
- `rsp_data` output `WORD_W`, READ result
- `rsp_count` output `CNT_W`, COUNT result
- `tags` output `CELLS`, current tag register
- `some_none` output 1, OR of all tags

## Operation
- A command is accepted on a rising edge with `cmd_valid && cmd_ready`. The opcode and operands are sampled at that edge.
- Opcodes:
  - 0 SET_ALL: tags = all ones.
  - 1 SEARCH: tag[i] &= (((word[i] ^ comparand) & mask) == 0). A zero mask leaves tags unchanged.
  - 2 SELECT_FIRST: keep only the lowest-index set tag. No tags set: no change.
  - 3 WRITE: for each tagged cell, word[i] = (word[i] & ~mask) | (comparand & mask). Untagged cells and the tags themselves are unchanged.
  - 4 READ: rsp_data = OR over tagged words. No tags set: 0.
  - 5 COUNT: rsp_count = number of set tags, accumulated `CHUNK` tags per cycle.
  - 6 CLEAR: tags = 0.
  - 7 NOP: no state change. The response is still produced, with data/count 0.
- FSM states:
  - IDLE: `cmd_ready`=1.
  - ACCEPT of ops 0-4, 6, 7 moves IDLE to RESP.
  - ACCEPT of op 5 moves IDLE to COUNT. The accumulator and chunk index are cleared.
  - COUNT runs for NCH = ceil(`CELLS`/`CHUNK`) cycles, then moves to RESP. The last chunk is zero-padded.
  - RESP: `rsp_valid`=1 for exactly one cycle, then IDLE.
- `rsp_data`/`rsp_count` are registered. They hold their last value until the next response and are meaningful only with `rsp_valid`.
- Tags and words cannot change during COUNT, because no command can be accepted then.
- `some_none` is combinational from the tag register.

## Timing
- Reset (asserted asynchronously) sets:
  - all words 0, tags 0, `some_none` 0
  - state IDLE, `cmd_ready` 1
  - `rsp_valid` 0, `rsp_data` 0, `rsp_count` 0
- Single-cycle ops accepted at edge k:
  - tag/word update visible after edge k
  - `rsp_valid` high in cycle k+1, `cmd_ready` low in cycle k+1
  - next accept possible at edge k+2
  - throughput is one op per 2 cycles
- COUNT accepted at edge k: `rsp_valid` high in cycle k+NCH+1. With the defaults, NCH=7.
- READ result reflects tags and words at the acceptance edge.
- `cmd_valid` while `cmd_ready`=0 is ignored. The host must hold the command; it is not captured.
- Reset asserted mid-COUNT or mid-RESP: the operation aborts, no `rsp_valid` is produced, and the FSM is in IDLE after deassertion.

## Structure
- Package `capp_pkg`:
  - opcode enum `capp_op_e`
  - FSM state enum
  - helper localparam function for NCH
- Sub-module `capp_first_one`:
  - parametrised `CELLS`-wide lowest-set-bit isolator (in & ~(in - 1) style)
  - used by SELECT_FIRST
- Per-cell match and write logic is generated inline with a generate loop.

## Test plan
- Reset then SET_ALL; SEARCH with comparand=0, mask=1 on the all-zero array -> tags all ones, `some_none`=1, `rsp_valid` at k+1. Then COUNT -> `rsp_count`=100 at k+8.
- SET_ALL; SELECT_FIRST; WRITE comparand=32'hA5, mask=32'hFF -> only cell 0 = 32'hA5. SET_ALL; SEARCH 32'hA5/32'hFF -> tags = 1 (bit 0 only), COUNT = 1.
- Write cells 3 and 97 with 32'h0F00 and 32'h00F0 (tag via SELECT_FIRST sequences). Search mask 0; READ with tags {3,97} -> `rsp_data`=32'h0FF0. CLEAR then READ -> 0, `some_none`=0.
- Masked write: cell holding 32'hFFFF_FFFF, WRITE comparand 0, mask 32'h0000_FF00 -> 32'hFFFF_00FF.
- Hold `cmd_valid` through RESP and COUNT cycles -> exactly one accept per command. Back-to-back ops are accepted every 2nd edge.
- Assert `RST_N` low in the 3rd COUNT cycle -> no `rsp_valid`, all outputs at reset values, and the first command after release is accepted.

Source files
------------

// File: rtl/capp_pkg.sv
// Shared types for the associative-processing core: opcodes, FSM states and
// the COUNT chunk-count helper.
package capp_pkg;

    typedef enum logic [2:0] {
        OP_SET_ALL      = 3'd0,
        OP_SEARCH       = 3'd1,
        OP_SELECT_FIRST = 3'd2,
        OP_WRITE        = 3'd3,
        OP_READ         = 3'd4,
        OP_COUNT        = 3'd5,
        OP_CLEAR        = 3'd6,
        OP_NOP          = 3'd7
    } capp_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_RESP
    } capp_state_e;

    // Number of COUNT cycles; the last chunk is zero-padded.
    function automatic int capp_nch(input int cells, input int chunk);
        return (cells + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/capp_first_one.sv
// Lowest-set-bit isolator: keeps only the least significant one of vec.
module capp_first_one #(
    parameter int CELLS = 100
) (
    input  logic [CELLS-1:0] vec,
    output logic [CELLS-1:0] first
);

    assign first = vec & ~(vec - CELLS'(1));

endmodule

// File: rtl/capp_array.sv
// Associative-processing core: CELLS words with per-cell tags, driven by a
// single valid/ready command port; one-cycle ops respond after one cycle.
module capp_array
    import capp_pkg::*;
#(
    parameter  int WORD_W = 32,
    parameter  int CELLS  = 100,
    parameter  int CHUNK  = 16,
    localparam int CNT_W  = $clog2(CELLS + 1)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [WORD_W-1:0] cmd_comparand,
    input  logic [WORD_W-1:0] cmd_mask,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_data,
    output logic [CNT_W-1:0]  rsp_count,
    output logic [CELLS-1:0]  tags,
    output logic              some_none
);

    localparam int NCH   = capp_nch(CELLS, CHUNK);
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    capp_state_e          state_q, state_d;
    capp_op_e             op;
    logic                 accept, last_chunk;
    logic [CELLS-1:0]     tag_q, tag_d, match, first_tag;
    logic [WORD_W-1:0]    word_q   [CELLS];
    logic [WORD_W-1:0]    word_new [CELLS];
    logic [WORD_W-1:0]    read_or;
    logic [IDX_W-1:0]     chunk_idx;
    logic [CNT_W-1:0]     acc, chunk_sum;
    logic [NCH*CHUNK-1:0] tags_pad;
    logic [CHUNK-1:0]     chunk_bits;

    assign op         = capp_op_e'(cmd_op);
    assign accept     = cmd_valid && cmd_ready;
    assign last_chunk = (chunk_idx == IDX_W'(NCH - 1));
    assign tags       = tag_q;
    assign some_none  = |tag_q;

    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        assign match[i]    = ((word_q[i] ^ cmd_comparand) & cmd_mask) == '0;
        assign word_new[i] = (word_q[i] & ~cmd_mask) | (cmd_comparand & cmd_mask);
    end

    capp_first_one #(.CELLS(CELLS)) u_first_one (
        .vec   (tag_q),
        .first (first_tag)
    );

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = (op == OP_COUNT) ? ST_COUNT : ST_RESP;
            end
            ST_COUNT: if (last_chunk) state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tag_d = tag_q;
        if (accept) begin
            case (op)
                OP_SET_ALL:      tag_d = '1;
                OP_SEARCH:       tag_d = tag_q & match;
                OP_SELECT_FIRST: tag_d = first_tag;
                OP_CLEAR:        tag_d = '0;
                default:         tag_d = tag_q;
            endcase
        end
    end

    // Wired-OR read across tagged words and popcount of the current tag chunk.
    always_comb begin
        read_or = '0;
        for (int i = 0; i < CELLS; i++) begin
            if (tag_q[i]) read_or = read_or | word_q[i];
        end
        tags_pad             = '0;
        tags_pad[CELLS-1:0]  = tag_q;
        chunk_bits           = tags_pad[int'(chunk_idx) * CHUNK +: CHUNK];
        chunk_sum            = '0;
        for (int j = 0; j < CHUNK; j++) begin
            chunk_sum = chunk_sum + CNT_W'(chunk_bits[j]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            tag_q     <= '0;
            chunk_idx <= '0;
            acc       <= '0;
            rsp_data  <= '0;
            rsp_count <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            if (accept) begin
                case (op)
                    OP_READ:  rsp_data <= read_or;
                    OP_COUNT: begin
                        acc       <= '0;
                        chunk_idx <= '0;
                    end
                    OP_NOP: begin
                        rsp_data  <= '0;
                        rsp_count <= '0;
                    end
                    default: ;
                endcase
            end
            if (state_q == ST_COUNT) begin
                acc       <= acc + chunk_sum;
                chunk_idx <= chunk_idx + 1'b1;
                if (last_chunk) rsp_count <= acc + chunk_sum;
            end
        end
    end

    // NOTE: the word array is reset because cleared words are architecturally visible to SEARCH/READ.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < CELLS; i++) word_q[i] <= '0;
        end else if (accept && op == OP_WRITE) begin
            for (int i = 0; i < CELLS; i++) begin
                if (tag_q[i]) word_q[i] <= word_new[i];
            end
        end
    end

endmodule

// File: tb/tb_capp_array.sv
// Randomized and directed bench for capp_array against a behavioural
// array-of-words / tag-vector model.
module tb_capp_array;
    import capp_pkg::*;

    localparam int WORD_W = 32;
    localparam int CELLS  = 100;
    localparam int CHUNK  = 16;
    localparam int CNT_W  = $clog2(CELLS + 1);
    localparam int NCH    = (CELLS + CHUNK - 1) / CHUNK;

    localparam logic [WORD_W-1:0] MARK = 32'h8000_0000;
    localparam logic [WORD_W-1:0] GRP  = 32'h2000_0000;

    logic              CLK = 1'b0;
    logic              RST_N;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [WORD_W-1:0] cmd_comparand;
    logic [WORD_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_data;
    logic [CNT_W-1:0]  rsp_count;
    logic [CELLS-1:0]  tags;
    logic              some_none;

    int n_vec = 0;
    int n_err = 0;

    logic [WORD_W-1:0] m_word [CELLS];
    logic [CELLS-1:0]  m_tags;
    logic [WORD_W-1:0] obs_data;
    logic [CNT_W-1:0]  obs_cnt;

    capp_array #(.WORD_W(WORD_W), .CELLS(CELLS), .CHUNK(CHUNK)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_comparand (cmd_comparand),
        .cmd_mask      (cmd_mask),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_count     (rsp_count),
        .tags          (tags),
        .some_none     (some_none)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < CELLS; i++) m_word[i] = '0;
        m_tags = '0;
    endfunction

    function automatic void model_apply(input capp_op_e op, input logic [WORD_W-1:0] c,
                                        input logic [WORD_W-1:0] m,
                                        output logic [WORD_W-1:0] e_data,
                                        output logic [CNT_W-1:0] e_cnt);
        bit found = 0;
        e_data = '0;
        e_cnt  = '0;
        case (op)
            OP_SET_ALL: m_tags = '1;
            OP_SEARCH:
                for (int i = 0; i < CELLS; i++)
                    if (((m_word[i] ^ c) & m) != 0) m_tags[i] = 1'b0;
            OP_SELECT_FIRST:
                for (int i = 0; i < CELLS; i++)
                    if (m_tags[i]) begin
                        if (found) m_tags[i] = 1'b0;
                        found = 1;
                    end
            OP_WRITE:
                for (int i = 0; i < CELLS; i++)
                    if (m_tags[i]) m_word[i] = (m_word[i] & ~m) | (c & m);
            OP_READ:
                for (int i = 0; i < CELLS; i++)
                    if (m_tags[i]) e_data = e_data | m_word[i];
            OP_COUNT: e_cnt = CNT_W'($countones(m_tags));
            OP_CLEAR: m_tags = '0;
            default: ;
        endcase
    endfunction

    // Issue one command at #1 after an edge with the DUT idle; cmd_valid stays
    // high through the busy cycles to show it is not re-captured.
    task automatic run_cmd(input capp_op_e op, input logic [WORD_W-1:0] c,
                           input logic [WORD_W-1:0] m);
        int waited = 0;
        int lat = 0;
        logic [WORD_W-1:0] e_data;
        logic [CNT_W-1:0]  e_cnt;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_comparand = c;
        cmd_mask = m;
        while (!cmd_ready && waited < 20) begin
            @(posedge CLK); #1;
            waited++;
        end
        check("accept_wait", 128'(waited), 128'(0));
        model_apply(op, c, m, e_data, e_cnt);
        @(posedge CLK); #1;
        check("tags", 128'(tags), 128'(m_tags));
        check("some_none", 128'(some_none), 128'(|m_tags));
        while (!rsp_valid && lat < NCH + 4) begin
            @(posedge CLK); #1;
            lat++;
        end
        check("rsp_latency", 128'(lat), 128'((op == OP_COUNT) ? NCH : 0));
        check("busy_in_resp", 128'(cmd_ready), 128'(0));
        obs_data = rsp_data;
        obs_cnt  = rsp_count;
        if (op == OP_READ || op == OP_NOP) check("rsp_data", 128'(rsp_data), 128'(e_data));
        if (op == OP_COUNT || op == OP_NOP) check("rsp_count", 128'(rsp_count), 128'(e_cnt));
        @(posedge CLK); #1;
        check("rsp_one_pulse", 128'(rsp_valid), 128'(0));
        check("ready_again", 128'(cmd_ready), 128'(1));
        cmd_valid = 1'b0;
    endtask

    // Leaves exactly cell idx tagged, walking a marker bit up from cell 0.
    task automatic tag_only(input int idx);
        run_cmd(OP_SET_ALL, '0, '0);
        run_cmd(OP_WRITE, '0, MARK);
        for (int j = 0; j <= idx; j++) begin
            run_cmd(OP_SET_ALL, '0, '0);
            run_cmd(OP_SEARCH, '0, MARK);
            run_cmd(OP_SELECT_FIRST, '0, '0);
            run_cmd(OP_WRITE, MARK, MARK);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        check({name, "_ready"}, 128'(cmd_ready), 128'(1));
        check({name, "_tags"}, 128'(tags), 128'(0));
        check({name, "_some_none"}, 128'(some_none), 128'(0));
        check({name, "_rsp_data"}, 128'(rsp_data), 128'(0));
        check({name, "_rsp_count"}, 128'(rsp_count), 128'(0));
    endtask

    task automatic reset_mid_count();
        cmd_valid = 1'b1;
        cmd_op = OP_COUNT;
        cmd_comparand = '0;
        cmd_mask = '0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("busy_3rd_count_cycle", 128'(cmd_ready), 128'(0));
        RST_N = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            check("no_rsp_in_reset", 128'(rsp_valid), 128'(0));
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < NCH + 2; k++) begin
            @(posedge CLK); #1;
            check("no_rsp_after_abort", 128'(rsp_valid), 128'(0));
        end
    endtask

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        capp_op_e op;
        logic [WORD_W-1:0] c, m;
        RST_N = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_comparand = '0;
        cmd_mask = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // All-zero array matches comparand 0 on bit 0; full count.
        run_cmd(OP_SET_ALL, '0, '0);
        run_cmd(OP_SEARCH, '0, 32'h1);
        check("dir_search_all", 128'(tags), 128'({CELLS{1'b1}}));
        check("dir_some_none_1", 128'(some_none), 128'(1));
        run_cmd(OP_COUNT, '0, '0);
        check("dir_count_100", 128'(obs_cnt), 128'(100));

        // Write cell 0 only, then find it again.
        run_cmd(OP_SET_ALL, '0, '0);
        run_cmd(OP_SELECT_FIRST, '0, '0);
        run_cmd(OP_WRITE, 32'hA5, 32'hFF);
        run_cmd(OP_SET_ALL, '0, '0);
        run_cmd(OP_SEARCH, 32'hA5, 32'hFF);
        check("dir_tags_cell0", 128'(tags), 128'(1));
        run_cmd(OP_COUNT, '0, '0);
        check("dir_count_1", 128'(obs_cnt), 128'(1));

        // Cells 3 and 97, wired-OR read.
        tag_only(3);
        run_cmd(OP_WRITE, GRP | 32'h0F00, '1);
        tag_only(97);
        run_cmd(OP_WRITE, GRP | 32'h00F0, '1);
        run_cmd(OP_SET_ALL, '0, '0);
        run_cmd(OP_WRITE, '0, MARK);
        run_cmd(OP_SET_ALL, '0, '0);
        run_cmd(OP_SEARCH, GRP, GRP);
        check("dir_tags_3_97", 128'(tags), (128'(1) << 3) | (128'(1) << 97));
        run_cmd(OP_WRITE, '0, GRP);
        run_cmd(OP_SEARCH, 32'hDEAD_BEEF, '0);
        run_cmd(OP_READ, '0, '0);
        check("dir_read_0ff0", 128'(obs_data), 128'(32'h0FF0));
        run_cmd(OP_CLEAR, '0, '0);
        run_cmd(OP_READ, '0, '0);
        check("dir_read_none", 128'(obs_data), 128'(0));
        check("dir_some_none_0", 128'(some_none), 128'(0));

        // Masked write on an all-ones cell.
        run_cmd(OP_SET_ALL, '0, '0);
        run_cmd(OP_SELECT_FIRST, '0, '0);
        run_cmd(OP_WRITE, '1, '1);
        run_cmd(OP_WRITE, '0, 32'h0000_FF00);
        run_cmd(OP_READ, '0, '0);
        check("dir_masked_write", 128'(obs_data), 128'(32'hFFFF_00FF));
        run_cmd(OP_NOP, '0, '0);

        // Reset mid-COUNT aborts; the next command is accepted immediately.
        run_cmd(OP_SET_ALL, '0, '0);
        reset_mid_count();
        run_cmd(OP_SET_ALL, '0, '0);
        run_cmd(OP_COUNT, '0, '0);
        check("post_rst_count", 128'(obs_cnt), 128'(100));

        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            op = (r > 7) ? OP_SET_ALL : capp_op_e'(r[2:0]);
            case ($urandom_range(0, 4))
                0: c = '0;
                1: c = 32'hA5;
                2: c = 32'h0F00;
                3: c = '1;
                default: c = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: m = '1;
                1: m = 32'hFF;
                2: m = 32'h0F0F;
                3: m = '0;
                default: m = $urandom;
            endcase
            run_cmd(op, c, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
